// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants for the 5-stage MIPS core.
// Opcode/funct encodings, the ALU operation codes that the EX stage consumes,
// and the control bundle that decode hands to the ID/EX register.
package id_ex_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_e;

    typedef struct packed {
        logic    regwrite;
        logic    memread;
        logic    memwrite;
        logic    memtoreg;
        logic    alusrc;
        logic    branch;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/id_ex_stage_main_decoder.sv
// main_decoder: pure combinational opcode/funct decode.
// Ports:
//   instr   - instruction word in decode
//   ctrl    - control bundle (all zero for unsupported encodings / NOP)
//   wr_addr - destination register (rd for R-type, rt for lw/addi, else 0)
//   rt_src  - rt is read as a source operand (R-type, sw, beq)
module main_decoder
    import id_ex_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic [4:0]  wr_addr,
    output logic        rt_src
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       fn_ok;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        ctrl    = CTRL_NONE;
        wr_addr = 5'd0;
        rt_src  = 1'b0;
        fn_ok   = 1'b1;
        if (instr != NOP_INSTR) begin
            case (opcode)
                OP_RTYPE: begin
                    rt_src = 1'b1;
                    case (funct)
                        FN_ADD:  ctrl.alu_op = ALU_ADD;
                        FN_SUB:  ctrl.alu_op = ALU_SUB;
                        FN_AND:  ctrl.alu_op = ALU_AND;
                        FN_OR:   ctrl.alu_op = ALU_OR;
                        FN_SLT:  ctrl.alu_op = ALU_SLT;
                        default: fn_ok = 1'b0;
                    endcase
                    if (fn_ok) begin
                        ctrl.regwrite = 1'b1;
                        wr_addr       = instr[15:11];
                    end
                end
                OP_LW: begin
                    ctrl.alu_op   = ALU_ADD;
                    ctrl.alusrc   = 1'b1;
                    ctrl.memread  = 1'b1;
                    ctrl.memtoreg = 1'b1;
                    ctrl.regwrite = 1'b1;
                    wr_addr       = instr[20:16];
                end
                OP_SW: begin
                    rt_src        = 1'b1;
                    ctrl.alu_op   = ALU_ADD;
                    ctrl.alusrc   = 1'b1;
                    ctrl.memwrite = 1'b1;
                end
                OP_BEQ: begin
                    rt_src        = 1'b1;
                    ctrl.alu_op   = ALU_SUB;
                    ctrl.branch   = 1'b1;
                end
                OP_ADDI: begin
                    ctrl.alu_op   = ALU_ADD;
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    wr_addr       = instr[20:16];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode stage plus ID/EX pipeline register.
// Ports:
//   clk, rst                  - clock, async active-high reset
//   id_valid/id_instr/id_pc4  - IF/ID contents
//   flush                     - branch taken in EX, kill decode instruction
//   rs_addr/rt_addr           - regfile read addresses (combinational)
//   rs_rdata/rt_rdata         - regfile read data
//   wb_regwrite/addr/data     - WB write port, bypassed into decode
//   stall                     - load-use hazard, hold PC and IF/ID
//   ex_*                      - registered operands and control for EX
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int          bit_size  = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [31:0]         id_instr,
    input  logic [31:0]         id_pc4,
    input  logic                flush,
    output logic [4:0]          rs_addr,
    output logic [4:0]          rt_addr,
    input  logic [bit_size-1:0] rs_rdata,
    input  logic [bit_size-1:0] rt_rdata,
    input  logic                wb_regwrite,
    input  logic [4:0]          wb_addr,
    input  logic [bit_size-1:0] wb_data,
    output logic                stall,
    output logic                ex_valid,
    output logic [31:0]         ex_pc4,
    output logic [bit_size-1:0] ex_rs_data,
    output logic [bit_size-1:0] ex_rt_data,
    output logic [bit_size-1:0] ex_imm,
    output logic [4:0]          ex_rs,
    output logic [4:0]          ex_rt,
    output logic [4:0]          ex_wr_addr,
    output logic [2:0]          ex_alu_op,
    output logic                ex_regwrite,
    output logic                ex_memread,
    output logic                ex_memwrite,
    output logic                ex_memtoreg,
    output logic                ex_alusrc,
    output logic                ex_branch
);

    ctrl_t               dec_ctrl;
    logic [4:0]          dec_wr;
    logic                dec_rt_src;
    logic                hazard;
    logic                bubble;
    logic [bit_size-1:0] rs_val;
    logic [bit_size-1:0] rt_val;
    logic [bit_size-1:0] imm_sx;

    assign rs_addr = id_instr[25:21];
    assign rt_addr = id_instr[20:16];

    main_decoder #(.NOP_INSTR(NOP_INSTR)) u_dec (
        .instr   (id_instr),
        .ctrl    (dec_ctrl),
        .wr_addr (dec_wr),
        .rt_src  (dec_rt_src)
    );

    // Regfile only commits at the edge, so a same-cycle WB write must be
    // forwarded here; $0 always reads as zero regardless of WB.
    function automatic logic [bit_size-1:0] opnd(input logic [4:0] a,
                                                 input logic [bit_size-1:0] rd);
        if (a == 5'd0)                        return '0;
        else if (wb_regwrite && wb_addr == a) return wb_data;
        else                                  return rd;
    endfunction

    assign rs_val = opnd(rs_addr, rs_rdata);
    assign rt_val = opnd(rt_addr, rt_rdata);
    assign imm_sx = {{(bit_size-16){id_instr[15]}}, id_instr[15:0]};

    assign hazard = id_valid && ex_valid && ex_memread && (ex_wr_addr != 5'd0) &&
                    ((ex_wr_addr == rs_addr) || (dec_rt_src && ex_wr_addr == rt_addr));
    // A flushed instruction is dead, so it must not freeze upstream.
    assign stall  = hazard && !flush;
    assign bubble = flush || hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble) begin
            if (rst) begin
                ex_valid <= 1'b0;
            end else begin
                ex_valid <= 1'b0;
            end
            ex_pc4      <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_wr_addr  <= '0;
            ex_alu_op   <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_branch   <= 1'b0;
        end else begin
            ex_valid    <= id_valid;
            ex_pc4      <= id_pc4;
            ex_rs_data  <= rs_val;
            ex_rt_data  <= rt_val;
            ex_imm      <= imm_sx;
            ex_rs       <= rs_addr;
            ex_rt       <= rt_addr;
            ex_wr_addr  <= dec_wr;
            ex_alu_op   <= id_valid ? dec_ctrl.alu_op : 3'b000;
            ex_regwrite <= id_valid && dec_ctrl.regwrite;
            ex_memread  <= id_valid && dec_ctrl.memread;
            ex_memwrite <= id_valid && dec_ctrl.memwrite;
            ex_memtoreg <= id_valid && dec_ctrl.memtoreg;
            ex_alusrc   <= id_valid && dec_ctrl.alusrc;
            ex_branch   <= id_valid && dec_ctrl.branch;
        end
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register of the 5-stage MIPS core.
- Drives the register-file read addresses and consumes the read data.
- Applies write-through bypass from WB and forces $0 reads to zero.
- Decodes control and registers everything for EX; detects load-use hazards and stalls IF/ID.

Parameters:
bit_size, 32, datapath width
NOP_INSTR, 32'h0000_0000, instruction treated as bubble (sll $0,$0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  IF/ID holds a valid instruction
id_instr  in  32  instruction from IF/ID
id_pc4  in  32  PC+4 from IF/ID
flush  in  1  branch taken in EX: kill decode-stage instruction
rs_addr  out  5  regfile read address 1 (combinational = id_instr[25:21])
rt_addr  out  5  regfile read address 2 (= id_instr[20:16])
rs_rdata  in  bit_size  regfile read data 1
rt_rdata  in  bit_size  regfile read data 2
wb_regwrite  in  1  WB writes regfile this cycle
wb_addr  in  5  WB destination
wb_data  in  bit_size  WB data
stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  EX-stage instruction valid
ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  32/bit_size  registered operands; imm sign-extended
ex_rs, ex_rt, ex_wr_addr  out  5  registered register numbers
ex_alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch  out  1  registered control

Behaviour:
- Decode (combinational), opcode = instr[31:26]:
  - 0x00 R-type, funct 0x20/0x22/0x24/0x25/0x2A: add/sub/and/or/slt; wr = rd; regwrite = 1.
  - 0x23 lw: add, alusrc, memread, memtoreg, regwrite; wr = rt.
  - 0x2B sw: add, alusrc, memwrite.
  - 0x04 beq: sub, branch.
  - 0x08 addi: add, alusrc, regwrite; wr = rt.
  - Anything else, unknown funct, or NOP_INSTR: all control = 0 and wr_addr = 0; valid still follows id_valid.
- Operand select, per port: addr==0 gives 0; else wb_regwrite && wb_addr==addr gives wb_data; else regfile data. Write-through is required because the regfile updates only at the clock edge.
- Load-use hazard (stall=1) when all hold:
  - id_valid, ex_valid, ex_memread, ex_wr_addr!=0;
  - ex_wr_addr==rs_addr, or ex_wr_addr==rt_addr for R-type/sw/beq. rt is not a source for lw/addi.
- Register update each posedge:
  - flush=1: load a bubble (ex_valid=0, all control 0). flush wins over stall; stall output is forced to 0 when flush=1.
  - else stall=1: load a bubble; upstream holds, so the instruction re-decodes next cycle.
  - else: ex_valid = id_valid; all fields loaded; control gated to 0 when id_valid=0.
- Latency: 1 cycle ID to EX; a single load-use stall costs exactly 1 bubble.
- Reset (async): all ex_* outputs 0, ex_valid=0. stall is 0 while in reset. The first valid instruction after deassert appears at ex_* one edge later.
- Flush and WB bypass in the same cycle: bypass irrelevant, bubble loaded.

Decomposition:
- Shared package holds opcode/funct constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, FN_ADD …) and ALU_OP codes. The same codes are consumed by the ALU/EX stage.
- One sub-module, main_decoder: pure combinational opcode/funct to control + alu_op + wr_addr select.
- Hazard, bypass and pipeline register stay in id_ex_stage.

Test Plan:
- Reset mid-stream: rst pulse while ex_valid=1 -> all ex_* immediately 0, stall=0; next instr addi $1,$0,5 -> ex_imm=5, ex_wr_addr=1, ex_alusrc=1, ex_regwrite=1 one cycle after rst drops.
- WB bypass: rs_rdata=0x11, wb_regwrite=1, wb_addr=rs_addr=3, wb_data=0xABCD -> ex_rs_data=0xABCD; the same with wb_addr=0 and rs_addr=0 -> ex_rs_data=0.
- Load-use: lw $2,0($1) then add $3,$2,$4 -> stall=1 for exactly 1 cycle, bubble in EX (ex_valid=0), then add issues with ex_rs=2; lw $2 then addi $5,$6,1 -> no stall.
- Hazard not against rt of lw: lw $2 then lw $2,4($7) -> no stall; lw $0 then add using $0 -> no stall.
- Flush beats stall: the load-use condition present and flush=1 in the same cycle -> stall=0, ex_valid=0 next edge.
- Decode coverage: sw, beq, slt, an unknown opcode 0x3F -> control vectors as specified; unknown gives all control 0, ex_valid follows id_valid; negative imm 0xFFFC -> ex_imm=0xFFFF_FFFC.
